// File: rtl/fm_sb_playback_reader_if.sv
// rtl/fm_sb_playback_reader_if.sv - memory read port and playback stream bundle for the playback reader
interface fm_sb_playback_reader_if #(
  parameter int AXI_DW = 32,
  parameter int TP_DW  = 51,
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [AXI_DW-1:0] mem_rd_data;
  logic [TP_DW-1:0]  pb_data;
  logic              pb_vld;
  logic              pb_ready;

  modport master (
    output mem_rd_en, mem_rd_addr, pb_data, pb_vld,
    input  mem_rd_data, pb_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, pb_data, pb_vld,
    output mem_rd_data, pb_ready
  );
endinterface

// File: rtl/fm_sb_playback_reader.sv
// rtl/fm_sb_playback_reader.sv - reads playback memory, reassembles SB_DW words, streams TP_DW payloads
// Optional feature macro: FM_PB_LOOP_CNT_EN adds pb_loop_cnt (completed loop passes, saturating).
module fm_sb_playback_reader #(
  parameter int AXI_DW = 32,
  parameter int SB_DW  = 64,
  parameter int TP_DW  = 51,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            pb_mode,
  input  logic                  pb_start,
  input  logic [ADDR_W-1:0]     pb_last_addr,
  fm_sb_playback_reader_if.master bus,
  output logic                  pb_busy,
  output logic                  pb_done,
  output logic                  pb_err_len,
  output logic [ADDR_W-1:0]     pb_word_cnt
`ifdef FM_PB_LOOP_CNT_EN
  ,
  output logic [15:0]           pb_loop_cnt
`endif
);

  localparam int R  = SB_DW / AXI_DW;
  localparam int CW = $clog2(R + 1);
  localparam logic [ADDR_W:0] R_A    = (ADDR_W + 1)'(R);
  localparam logic [CW-1:0]   R_LAST = CW'(R - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE, DRAIN} state_t;

  state_t            state, state_d;
  logic [ADDR_W:0]   addr, last;
  logic [CW-1:0]     fcnt, rcnt;
  logic [RD_LAT-1:0] vpipe;
  logic [TP_DW-1:0]  sb_buf;
  logic [ADDR_W:0]   len_w, addr_nxt;
  logic              run_mode, ret, collecting, accept, start_ok, len_ok, pass_end;
  logic              rd_en, vld;

  assign run_mode   = (pb_mode == 2'd1) || (pb_mode == 2'd2);
  assign ret        = vpipe[RD_LAT-1];
  assign collecting = (state == FETCH) || (state == WAIT);
  assign accept     = (state == PRESENT) && bus.pb_ready;
  assign start_ok   = ((state == IDLE) || (state == DONE)) && pb_start && run_mode;
  assign len_w      = {1'b0, pb_last_addr} + (ADDR_W + 1)'(1);
  assign len_ok     = (len_w % R_A) == '0;
  // Wider-than-address compare so L = 2^ADDR_W-1 ends cleanly instead of wrapping.
  assign addr_nxt   = addr + R_A;
  assign pass_end   = addr_nxt > last;

  // Next-state and output decode; modes 0/3 abort any active fetch/collect/present.
  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    vld     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_d = len_ok ? FETCH : IDLE;
      end
      DONE: begin
        if (start_ok)       state_d = len_ok ? FETCH : IDLE;
        else if (!run_mode) state_d = IDLE;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (!run_mode)            state_d = DRAIN;
        else if (fcnt == R_LAST)  state_d = WAIT;
      end
      WAIT: begin
        if (!run_mode)                    state_d = DRAIN;
        else if (ret && rcnt == R_LAST)   state_d = PRESENT;
      end
      PRESENT: begin
        vld = 1'b1;
        if (!run_mode)   state_d = DRAIN;
        else if (accept) state_d = (pass_end && pb_mode == 2'd1) ? DONE : FETCH;
      end
      DRAIN: begin
        if (vpipe == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Address, read pipe, collect counters and run status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      last        <= '0;
      fcnt        <= '0;
      rcnt        <= '0;
      vpipe       <= '0;
      pb_err_len  <= 1'b0;
      pb_word_cnt <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(rd_en);
      fcnt  <= (state == FETCH) ? fcnt + CW'(1) : '0;
      if (!collecting) rcnt <= '0;
      else if (ret)    rcnt <= rcnt + CW'(1);
      if (start_ok) begin
        addr        <= '0;
        last        <= {1'b0, pb_last_addr};
        pb_err_len  <= !len_ok;
        pb_word_cnt <= '0;
      end else if (accept) begin
        addr        <= pass_end ? '0 : addr_nxt;
        pb_word_cnt <= pb_word_cnt + ADDR_W'(1);
      end
    end
  end

  // Returning words land little-endian by word; only payload bits are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_buf <= '0;
    end else if (collecting && ret) begin
      for (int b = 0; b < TP_DW; b++) begin
        if (int'(rcnt) == b / AXI_DW) sb_buf[b] <= bus.mem_rd_data[b % AXI_DW];
      end
    end
  end

`ifdef FM_PB_LOOP_CNT_EN
  // Completed loop passes, counted on the wrap back to address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                    pb_loop_cnt <= '0;
    else if (start_ok)                                          pb_loop_cnt <= '0;
    else if (accept && pass_end && pb_mode == 2'd2 && pb_loop_cnt != 16'hFFFF)
                                                                pb_loop_cnt <= pb_loop_cnt + 16'd1;
  end
`endif

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_en ? addr[ADDR_W-1:0] + ADDR_W'(fcnt) : '0;
  assign bus.pb_vld      = vld;
  assign bus.pb_data     = vld ? sb_buf : '0;
  assign pb_busy         = (state != IDLE) && (state != DONE);
  assign pb_done         = (state == DONE);

endmodule

// File: tb/tb_fm_sb_playback_reader.sv
// tb/tb_fm_sb_playback_reader.sv - scoreboard bench for fm_sb_playback_reader
module tb_fm_sb_playback_reader;
  localparam int AXI_DW = 32, SB_DW = 64, TP_DW = 51, ADDR_W = 10, RD_LAT = 2;
  localparam int R = SB_DW / AXI_DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        pb_mode = 2'd0;
  logic              pb_start = 1'b0;
  logic [ADDR_W-1:0] pb_last_addr = '0;
  logic              pb_busy, pb_done, pb_err_len;
  logic [ADDR_W-1:0] pb_word_cnt;
`ifdef FM_PB_LOOP_CNT_EN
  logic [15:0]       pb_loop_cnt;
`endif

  fm_sb_playback_reader_if #(.AXI_DW(AXI_DW), .TP_DW(TP_DW), .ADDR_W(ADDR_W)) bus ();

  fm_sb_playback_reader #(
    .AXI_DW(AXI_DW), .SB_DW(SB_DW), .TP_DW(TP_DW), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .pb_mode(pb_mode), .pb_start(pb_start), .pb_last_addr(pb_last_addr),
    .bus(bus), .pb_busy(pb_busy), .pb_done(pb_done), .pb_err_len(pb_err_len),
    .pb_word_cnt(pb_word_cnt)
`ifdef FM_PB_LOOP_CNT_EN
    , .pb_loop_cnt(pb_loop_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Playback memory with a two-stage read pipe.
  logic [31:0] mem [0:1023];
  logic [31:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    p0 <= bus.mem_rd_en ? mem[bus.mem_rd_addr] : 32'hDEAD_BEEF;
    p1 <= p0;
  end
  assign bus.mem_rd_data = p1;

  // Downstream ready: forced level or random, updated 2 ns after each edge.
  bit   ready_rand  = 1'b0;
  logic ready_force = 1'b1;
  initial begin
    bus.pb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.pb_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  function automatic logic [TP_DW-1:0] beat(int w);
    logic [63:0] v;
    v = {mem[2*w+1], mem[2*w]};
    return v[TP_DW-1:0];
  endfunction

  // Scoreboard monitor.
  logic [TP_DW-1:0] exp_q[$];
  int acc_cnt = 0, rd_cnt = 0, lat = 0;
  bit lat_arm = 1'b0, holding = 1'b0;
  logic [TP_DW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_arm = 1'b0;
      holding = 1'b0;
    end else begin
      if (bus.mem_rd_en) rd_cnt++;
      if (lat_arm) lat++;
      if (!pb_busy) lat_arm = 1'b0;
      if (bus.pb_vld) begin
        if (lat_arm) begin
          check("accept_to_vld", lat, R + RD_LAT + 1);
          lat_arm = 1'b0;
        end
        check("rd_en_in_present", bus.mem_rd_en, 0);
        if (holding) check("hold_data", bus.pb_data, hold_data);
        if (bus.pb_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", bus.pb_data);
          end else begin
            check("beat", bus.pb_data, exp_q.pop_front());
          end
          acc_cnt++;
          lat_arm = 1'b1;
          lat = 0;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          hold_data = bus.pb_data;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [1:0] m, int l);
    pb_mode = m;
    pb_last_addr = ADDR_W'(l);
    pb_start = 1'b1;
    cyc(1);
    pb_start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (pb_busy && n < budget) begin cyc(1); n++; end
    check(name, pb_busy, 0);
  endtask

  task automatic wait_vld(string name, int budget);
    int n = 0;
    while (!bus.pb_vld && n < budget) begin cyc(1); n++; end
    check(name, bus.pb_vld, 1);
  endtask

  task automatic push_words01();
    exp_q.push_back(51'h2_2222_1111_1111);
    exp_q.push_back(51'h4_4444_3333_3333);
  endtask

  function automatic logic [63:0] ctrl_vec();
    return {bus.mem_rd_en, bus.pb_vld, pb_busy, pb_done, pb_err_len, bus.mem_rd_addr, pb_word_cnt};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, acc0, last_acc, n, l;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;

    // Reset state, then reset asserted mid-FETCH.
    cyc(3);
    check("reset_ctrl", ctrl_vec(), 0);
    check("reset_data", bus.pb_data, 0);
`ifdef FM_PB_LOOP_CNT_EN
    check("reset_loop_cnt", pb_loop_cnt, 0);
`endif
    rst = 1'b0;
    cyc(1);
    do_start(2'd1, 3);
    check("fetch_started", bus.mem_rd_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_ctrl", ctrl_vec(), 0);
    check("async_reset_data", bus.pb_data, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("busy_after_reset", pb_busy, 0);

    // Single-shot pass over words 0..3.
    rd0 = rd_cnt; acc0 = acc_cnt;
    push_words01();
    do_start(2'd1, 3);
    wait_idle("t2_idle", 100);
    check("t2_done", pb_done, 1);
    check("t2_word_cnt", pb_word_cnt, 2);
    check("t2_rd_en_cycles", rd_cnt - rd0, 4);
    check("t2_accepts", acc_cnt - acc0, 2);
    check("t2_queue_empty", exp_q.size(), 0);

    // Backpressure for 5 cycles on the first beat.
    ready_force = 1'b0;
    push_words01();
    do_start(2'd1, 3);
    wait_vld("t3_first_vld", 50);
    for (int k = 0; k < 5; k++) begin
      check("t3_vld_held", bus.pb_vld, 1);
      check("t3_data_held", bus.pb_data, 51'h2_2222_1111_1111);
      check("t3_no_rd_en", bus.mem_rd_en, 0);
      cyc(1);
    end
    ready_force = 1'b1;
    wait_idle("t3_idle", 100);
    check("t3_word_cnt", pb_word_cnt, 2);
    check("t3_done", pb_done, 1);

    // Loop mode with random ready for three passes, then abort in FETCH.
    ready_rand = 1'b1;
    acc0 = acc_cnt;
    for (int k = 0; k < 3; k++) push_words01();
    do_start(2'd2, 3);
    n = 0; last_acc = 0;
    while (acc_cnt - acc0 < 6 && n < 600) begin
      cyc(1);
      n++;
`ifdef FM_PB_LOOP_CNT_EN
      if (acc_cnt - acc0 != last_acc && ((acc_cnt - acc0) % 2) == 0)
        check("t4_loop_cnt", pb_loop_cnt, (acc_cnt - acc0) / 2);
`endif
      last_acc = acc_cnt - acc0;
    end
    pb_mode = 2'd0;
    check("t4_accepts", acc_cnt - acc0, 6);
    wait_idle("t4_idle", 20);
    check("t4_word_cnt", pb_word_cnt, 6);
    check("t4_done", pb_done, 0);
    check("t4_queue_empty", exp_q.size(), 0);
    ready_rand = 1'b0;
    ready_force = 1'b1;

    // Length error: (L+1) not a multiple of R.
    rd0 = rd_cnt;
    do_start(2'd1, 2);
    check("t5_err_len", pb_err_len, 1);
    check("t5_busy", pb_busy, 0);
    check("t5_word_cnt_cleared", pb_word_cnt, 0);
    cyc(5);
    check("t5_no_rd_en", rd_cnt - rd0, 0);
    check("t5_err_sticky", pb_err_len, 1);

    // Abort one cycle after FETCH ends, then restart.
    do_start(2'd1, 3);
    check("t6_err_cleared", pb_err_len, 0);
    cyc(2);
    pb_mode = 2'd0;
    cyc(1);
    check("t6_drain1_busy", {pb_busy, bus.pb_vld}, 2'b10);
    cyc(1);
    check("t6_drain2_busy", {pb_busy, bus.pb_vld}, 2'b10);
    cyc(1);
    check("t6_idle", {pb_busy, bus.pb_vld}, 2'b00);
    push_words01();
    do_start(2'd1, 3);
    wait_idle("t6_restart_idle", 100);
    check("t6_restart_word_cnt", pb_word_cnt, 2);
    check("t6_queue_empty", exp_q.size(), 0);

    // Full-memory pass (L = 2^ADDR_W-1), stray start and last_addr change mid-run.
    ready_rand = 1'b1;
    rd0 = rd_cnt; acc0 = acc_cnt;
    for (int w = 0; w < 1024 / R; w++) exp_q.push_back(beat(w));
    do_start(2'd1, 1023);
    cyc(50);
    pb_last_addr = 10'd5;
    pb_start = 1'b1;
    cyc(1);
    pb_start = 1'b0;
    wait_idle("t7_idle", 6000);
    check("t7_done", pb_done, 1);
    check("t7_word_cnt", pb_word_cnt, 512);
    check("t7_accepts", acc_cnt - acc0, 512);
    check("t7_rd_en_cycles", rd_cnt - rd0, 1024);
    check("t7_queue_empty", exp_q.size(), 0);

    // Random short single-shot runs.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      l = 2 * $urandom_range(0, 20) + 1;
      acc0 = acc_cnt;
      for (int w = 0; w < (l + 1) / R; w++) exp_q.push_back(beat(w));
      do_start(2'd1, l);
      wait_idle("t8_idle", 1000);
      check("t8_word_cnt", pb_word_cnt, (l + 1) / R);
      check("t8_accepts", acc_cnt - acc0, (l + 1) / R);
      check("t8_done", pb_done, 1);
    end
    ready_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
